// File: rtl/md_pkg.sv
// Shared op encodings and FSM state type for the HI/LO multiply/divide unit.
// The DIV state only exists when MD_UNIT_DIV_EN is defined.
package md_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1
`ifdef MD_UNIT_DIV_EN
    ,
    S_DIV  = 2'd2
`endif
  } md_state_e;

endpackage

// File: rtl/md_divider.sv
// Iterative restoring divider on operand magnitudes (one quotient bit per cycle), followed by
// a sign-fix cycle during which valid_o is high and the signed quotient/remainder are presented.
module md_divider
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             signed_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             valid_o
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q;
  logic             run_q, fix_q, neg_quo_q, neg_rem_q, div0_q;
  logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
  logic [WIDTH:0]   shift_d, diff_d;
  logic             a_neg_d, b_neg_d;

  assign a_neg_d = signed_i & a_i[WIDTH-1];
  assign b_neg_d = signed_i & b_i[WIDTH-1];
  // The dividend shifts out of quo_q into the partial remainder as quotient bits shift in.
  assign shift_d = {rem_q, quo_q[WIDTH-1]};
  assign diff_d  = shift_d - {1'b0, dvs_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      run_q     <= 1'b0;
      fix_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
    end else if (start_i) begin
      cnt_q     <= CW'(WIDTH);
      run_q     <= 1'b1;
      fix_q     <= 1'b0;
      neg_quo_q <= a_neg_d ^ b_neg_d;
      neg_rem_q <= a_neg_d;
      div0_q    <= (b_i == '0);
      quo_q     <= a_neg_d ? -a_i : a_i;
      rem_q     <= '0;
      dvs_q     <= b_neg_d ? -b_i : b_i;
    end else if (run_q) begin
      if (!diff_d[WIDTH]) begin
        rem_q <= diff_d[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= shift_d[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        run_q <= 1'b0;
        fix_q <= 1'b1;
      end
    end else begin
      fix_q <= 1'b0;
    end
  end

  // Magnitude of most-negative wraps back onto itself, which gives MIN/-1 = MIN with no special case.
  assign valid_o     = fix_q;
  assign quotient_o  = div0_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
  assign remainder_o = neg_rem_q ? -rem_q : rem_q;

endmodule

// File: rtl/md_unit.sv
// md_unit: MIPS-style HI/LO multiply/divide unit with fixed-latency multiply.
// Define MD_UNIT_DIV_EN to build the divider; without it DIV/DIVU are accepted as no-ops.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  md_state_e          state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   a_q, b_q, hi_q, lo_q;
  logic               sgn_q, busy_q, done_q;
  logic [2*WIDTH-1:0] a_ext_d, b_ext_d, prod_d;

  // Sign- or zero-extend to the full product width so one multiplier serves MULT and MULTU.
  assign a_ext_d = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
  assign b_ext_d = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
  assign prod_d  = a_ext_d * b_ext_d;

`ifdef MD_UNIT_DIV_EN
  logic             div_start_d;
  logic [WIDTH-1:0] div_quo, div_rem;
  logic             div_valid;

  assign div_start_d = start && (state_q == S_IDLE) && ((op == OP_DIV) || (op == OP_DIVU));

  md_divider #(.WIDTH(WIDTH)) u_div (
    .clk        (Clk),
    .rst        (Reset),
    .start_i    (div_start_d),
    .a_i        (A),
    .b_i        (B),
    .signed_i   (op == OP_DIV),
    .quotient_o (div_quo),
    .remainder_o(div_rem),
    .valid_o    (div_valid)
  );
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                a_q     <= A;
                b_q     <= B;
                sgn_q   <= (op == OP_MULT);
                cnt_q   <= CW'(MULT_LAT - 1);
                busy_q  <= 1'b1;
                state_q <= S_MUL;
              end
`ifdef MD_UNIT_DIV_EN
              OP_DIV, OP_DIVU: begin
                busy_q  <= 1'b1;
                state_q <= S_DIV;
              end
`else
              OP_DIV, OP_DIVU: ;
`endif
              OP_MTHI: hi_q <= A;
              OP_MTLO: lo_q <= A;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (cnt_q == '0) begin
            {hi_q, lo_q} <= prod_d;
            done_q       <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
`ifdef MD_UNIT_DIV_EN
        S_DIV: begin
          if (div_valid) begin
            hi_q    <= div_rem;
            lo_q    <= div_quo;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: a 32-bit/5-cycle instance and a 16-bit/1-cycle instance,
// checked against an arithmetic reference model; works with and without MD_UNIT_DIV_EN.
module tb_md_unit;
  import md_pkg::*;

`ifdef MD_UNIT_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int LAT32 = 5;
  localparam int LAT16 = 1;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op_s = 3'd0;
  logic [31:0] a_s = '0, b_s = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic        start16 = 1'b0;
  logic [2:0]  op16 = 3'd0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16;
  logic [15:0] hi16, lo16;

  logic [31:0] m_hi = '0, m_lo = '0;
  logic [15:0] m16_hi = '0, m16_lo = '0;
  int          n_checks = 0, n_fail = 0;

  always #5 Clk = ~Clk;

  md_unit #(.WIDTH(32), .MULT_LAT(LAT32)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .op(op_s), .A(a_s), .B(b_s),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  md_unit #(.WIDTH(16), .MULT_LAT(LAT16)) dut16 (
    .Clk(Clk), .Reset(Reset), .start(start16), .op(op16), .A(a16), .B(b16),
    .busy(busy16), .done(done16), .hi(hi16), .lo(lo16)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic string opname(input logic [2:0] o);
    case (o)
      OP_MULT:  return "MULT";
      OP_MULTU: return "MULTU";
      OP_DIV:   return "DIV";
      OP_DIVU:  return "DIVU";
      OP_MTHI:  return "MTHI";
      OP_MTLO:  return "MTLO";
      default:  return "NOP";
    endcase
  endfunction

  // Returns {new_hi, new_lo}, each in the low w bits of a 32-bit half.
  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                         input int w, input logic [31:0] h, input logic [31:0] l);
    logic [63:0] mask, ua, ub, p;
    longint      sa, sb;
    logic [31:0] nh, nl;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    sb = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    nh = h;
    nl = l;
    case (o)
      OP_MULT:  begin p = 64'(sa * sb); nh = 32'((p >> w) & mask); nl = 32'(p & mask); end
      OP_MULTU: begin p = ua * ub;      nh = 32'((p >> w) & mask); nl = 32'(p & mask); end
      OP_DIV, OP_DIVU: begin
        if (DIV_EN) begin
          if (ub == 64'd0) begin
            nl = 32'(mask);
            nh = 32'(ua);
          end else if (o == OP_DIV) begin
            nl = 32'(64'(sa / sb) & mask);
            nh = 32'(64'(sa % sb) & mask);
          end else begin
            nl = 32'(ua / ub);
            nh = 32'(ua % ub);
          end
        end
      end
      OP_MTHI: nh = 32'(ua);
      OP_MTLO: nl = 32'(ua);
      default: ;
    endcase
    return {nh, nl};
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input int w, input int mlat);
    if (o == OP_MULT || o == OP_MULTU) return mlat;
    if (o == OP_DIV || o == OP_DIVU) return DIV_EN ? w + 1 : 0;
    return 0;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(1, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issues one op on the 32-bit unit at the current negedge and returns at the negedge of its
  // done cycle. noise: 0 none, 1 random start requests while busy, 2 MTHI 0x1234 while busy.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int noise);
    logic [63:0] r;
    int          lat, n;
    r   = ref_op(o, a, b, 32, m_hi, m_lo);
    lat = ref_lat(o, 32, LAT32);
    start = 1'b1; op_s = o; a_s = a; b_s = b;
    @(negedge Clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (noise == 2) begin
        start = 1'b1; op_s = OP_MTHI; a_s = 32'h1234;
      end else if (noise == 1 && $urandom_range(0, 1) == 1) begin
        start = 1'b1; op_s = 3'($urandom_range(0, 7)); a_s = $urandom; b_s = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge Clk);
    end
    start = 1'b0;
    m_hi = r[63:32];
    m_lo = r[31:0];
    $display("op %-5s A=%h B=%h busy_cycles=%0d done=%b hi=%h lo=%h", opname(o), a, b, n, done, hi, lo);
    check_eq({opname(o), " busy cycles"}, 64'(n), 64'(lat));
    check_eq({opname(o), " done"}, 64'(done), 64'(lat != 0));
    check_eq({opname(o), " hi"}, 64'(hi), 64'(m_hi));
    check_eq({opname(o), " lo"}, 64'(lo), 64'(m_lo));
  endtask

  task automatic run16(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    logic [63:0] r;
    int          lat, n;
    r   = ref_op(o, {16'd0, a}, {16'd0, b}, 16, {16'd0, m16_hi}, {16'd0, m16_lo});
    lat = ref_lat(o, 16, LAT16);
    @(negedge Clk);
    start16 = 1'b1; op16 = o; a16 = a; b16 = b;
    @(negedge Clk);
    start16 = 1'b0;
    n = 0;
    while (busy16 && n < 100) begin
      n++;
      @(negedge Clk);
    end
    m16_hi = r[47:32];
    m16_lo = r[15:0];
    $display("w16 %-5s A=%h B=%h busy_cycles=%0d done=%b hi=%h lo=%h", opname(o), a, b, n, done16, hi16, lo16);
    check_eq({"w16 ", opname(o), " busy cycles"}, 64'(n), 64'(lat));
    check_eq({"w16 ", opname(o), " done"}, 64'(done16), 64'(lat != 0));
    check_eq({"w16 ", opname(o), " hi"}, 64'(hi16), 64'(m16_hi));
    check_eq({"w16 ", opname(o), " lo"}, 64'(lo16), 64'(m16_lo));
  endtask

  initial begin
    int          n, done_seen;
    logic [2:0]  o;
    logic [31:0] a, b;

    repeat (2) @(negedge Clk);
    check_eq("reset busy", 64'(busy), 64'(0));
    check_eq("reset done", 64'(done), 64'(0));
    check_eq("reset hi", 64'(hi), 64'(0));
    check_eq("reset lo", 64'(lo), 64'(0));
    check_eq("reset w16 hi/lo", 64'({hi16, lo16}), 64'(0));
    Reset = 1'b0;
    @(negedge Clk);

    // -2 * 3, then done must drop after one cycle.
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 0);
    check_eq("mult -2*3 hi const", 64'(hi), 64'hFFFF_FFFF);
    check_eq("mult -2*3 lo const", 64'(lo), 64'hFFFF_FFFA);
    @(negedge Clk);
    check_eq("done pulse width", 64'(done), 64'(0));

    // DIVU 100/7, then MTLO issued in the done cycle.
    @(negedge Clk);
    run_op(OP_DIVU, 32'd100, 32'd7, 0);
`ifdef MD_UNIT_DIV_EN
    check_eq("divu 100/7 lo const", 64'(lo), 64'd14);
    check_eq("divu 100/7 hi const", 64'(hi), 64'd2);
`endif
    run_op(OP_MTLO, 32'h55, 32'd0, 0);
    check_eq("mtlo in done cycle lo", 64'(lo), 64'h55);

    @(negedge Clk);
    run_op(OP_DIV, -32'd7, 32'd2, 0);
`ifdef MD_UNIT_DIV_EN
    check_eq("div -7/2 lo const", 64'(lo), 64'hFFFF_FFFD);
    check_eq("div -7/2 hi const", 64'(hi), 64'hFFFF_FFFF);
`endif
    @(negedge Clk);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
`ifdef MD_UNIT_DIV_EN
    check_eq("div min/-1 lo const", 64'(lo), 64'h8000_0000);
    check_eq("div min/-1 hi const", 64'(hi), 64'd0);
`endif
    run_op(OP_DIVU, 32'd5, 32'd0, 0);
`ifdef MD_UNIT_DIV_EN
    check_eq("divu 5/0 lo const", 64'(lo), 64'hFFFF_FFFF);
    check_eq("divu 5/0 hi const", 64'(hi), 64'd5);
`endif

    // MTHI requests while the multiply is busy must be ignored.
    @(negedge Clk);
    run_op(OP_MULT, 32'd7, 32'd9, 2);
    run_op(OP_DIV, 32'd1000, -32'd3, 0);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);

    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 5));
      a = pick();
      b = pick();
      if ($urandom_range(0, 2) == 0) begin
        @(negedge Clk);
        check_eq("gap done low", 64'(done), 64'(0));
        check_eq("gap hi/lo held", 64'({hi, lo}), {m_hi, m_lo});
      end
      run_op(o, a, b, int'($urandom_range(0, 1)));
    end

    // Reset in the middle of an operation: nothing may be written afterwards.
    @(negedge Clk);
    run_op(OP_MTHI, 32'hDEAD_BEEF, 32'd0, 0);
    run_op(OP_MTLO, 32'h0BAD_F00D, 32'd0, 0);
`ifdef MD_UNIT_DIV_EN
    start = 1'b1; op_s = OP_DIV; a_s = 32'd1000; b_s = 32'd3;
`else
    start = 1'b1; op_s = OP_MULT; a_s = 32'd1000; b_s = 32'd3;
`endif
    @(negedge Clk);
    start = 1'b0;
    n = 1;
`ifdef MD_UNIT_DIV_EN
    while (n < 10) begin
`else
    while (n < 3) begin
`endif
      @(negedge Clk);
      n++;
    end
    check_eq("busy before reset", 64'(busy), 64'(1));
    Reset = 1'b1;
    #1;
    check_eq("async reset busy", 64'(busy), 64'(0));
    check_eq("async reset done", 64'(done), 64'(0));
    check_eq("async reset hi", 64'(hi), 64'(0));
    check_eq("async reset lo", 64'(lo), 64'(0));
    m_hi = '0; m_lo = '0; m16_hi = '0; m16_lo = '0;
    @(negedge Clk);
    Reset = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(negedge Clk);
      if (done || busy) done_seen++;
    end
    check_eq("no done after reset", 64'(done_seen), 64'(0));
    check_eq("hi/lo stay zero after reset", 64'({hi, lo}), 64'(0));

    // 16-bit, single-cycle multiply build.
    run16(OP_MULTU, 16'hFFFF, 16'hFFFF);
    check_eq("w16 multu hi const", 64'(hi16), 64'hFFFE);
    check_eq("w16 multu lo const", 64'(lo16), 64'h0001);
    run16(OP_DIV, 16'h8000, 16'hFFFF);
    run16(OP_DIVU, 16'd9, 16'd0);
    for (int i = 0; i < 20; i++) begin
      run16(3'($urandom_range(0, 5)), 16'($urandom), 16'($urandom_range(0, 3) == 0 ? 0 : $urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (>=8, even).
REQ-002 SHALL have parameter MULT_LAT, default 5, multiply latency in cycles (>=1).
REQ-003 SHALL have port Clk  input  1  single clock, rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request strobe, sampled at Clk edge.
REQ-006 SHALL have port op  input  3  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-007 SHALL have port A  input  WIDTH  operand rs.
REQ-008 SHALL have port B  input  WIDTH  operand rt.
REQ-009 SHALL have port busy  output  1  high while a multiply/divide is in flight.
REQ-010 SHALL have port done  output  1  one-cycle pulse when HI/LO are updated by MULT/DIV.
REQ-011 SHALL have port hi  output  WIDTH  HI register.
REQ-012 SHALL have port lo  output  WIDTH  LO register.

Function
REQ-013 SHALL implement states IDLE, MUL, DIV; start accepted only in IDLE.
REQ-014 SHALL ignore start (any op, including MTHI/MTLO) while busy; no state or HI/LO change.
REQ-015 MTHI/MTLO SHALL write A into hi/lo at the accepting edge; busy stays low; no done.
REQ-016 MULT/MULTU SHALL latch operands, enter MUL, and hold busy high for exactly MULT_LAT cycles starting the cycle after acceptance.
REQ-017 Multiply result SHALL be the 2*WIDTH product, signed (MULT) or unsigned (MULTU); hi = upper WIDTH bits, lo = lower WIDTH bits.
REQ-018 DIV/DIVU SHALL enter DIV and hold busy high for exactly WIDTH+1 cycles (WIDTH iterations plus one sign-fix cycle).
REQ-019 Division SHALL set lo = quotient, truncated toward zero; hi = remainder, sign of the dividend.
REQ-020 Divide by zero SHALL yield lo = all ones, hi = A, with normal latency.
REQ-021 Signed most-negative / -1 SHALL yield lo = most-negative, hi = 0.
REQ-022 hi/lo SHALL update at the edge busy falls, with done high for that following cycle; state returns to IDLE at that edge.
REQ-023 start in the cycle done is high SHALL be accepted (back-to-back operations).
REQ-024 hi/lo SHALL hold their values at all times except at the update edges defined in REQ-015 and REQ-022.

Reset
REQ-025 Reset SHALL asynchronously force IDLE, busy = 0, done = 0, hi = 0, lo = 0, and clear the internal counter and operand registers.
REQ-026 Reset mid-operation SHALL abandon the operation; no partial result is ever written.

Configuration
REQ-027 Macro MD_UNIT_DIV_EN SHALL compile in the divider and the DIV state.
REQ-028 Without MD_UNIT_DIV_EN, DIV/DIVU SHALL be accepted as a no-op: busy stays low, no done, hi/lo unchanged.

Structure
REQ-029 Package md_pkg SHALL hold the op encodings and the state enum.
REQ-030 The iterative restoring divider SHALL be sub-module md_divider (start, operands, signedness in; quotient, remainder, valid out).
REQ-031 The multiply SHALL be a single product registered through a MULT_LAT-deep delay or counter; no sub-module.

Verification
REQ-032 Bench SHALL cover: MULT A=0xFFFFFFFE (-2), B=3 -> after 5 busy cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA, done one cycle.
REQ-033 Bench SHALL cover: DIVU A=100, B=7 -> 33 busy cycles, lo=14, hi=2; DIV A=-7, B=2 -> lo=-3, hi=-1.
REQ-034 Bench SHALL cover: DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU A=5, B=0 -> lo=0xFFFFFFFF, hi=5.
REQ-035 Bench SHALL cover: MTHI 0x1234 while busy -> ignored; MTLO 0x55 in the done cycle -> lo=0x55 next cycle.
REQ-036 Bench SHALL cover: Reset asserted at busy cycle 10 of a DIV -> immediately busy=0, hi=lo=0; no done afterwards.
REQ-037 Bench SHALL cover: WIDTH=16, MULT_LAT=1 build, MULTU 0xFFFF*0xFFFF -> hi=0xFFFE, lo=0x0001 after 1 busy cycle; each test also run without MD_UNIT_DIV_EN, DIV checked as a no-op.
